click_conditioner: RTL

Input conditioning stage directly upstream of the game logic block. It takes a raw, bouncy, asynchronous push-button level and produces clean one-cycle pulses on its `click` output, which feeds the game logic's `click` input. It also provides a debounced level, a long-press pulse and a saturating click counter for status and debug.

---
 rtl/click_conditioner.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/click_conditioner.sv
// click_conditioner: synchronizes and debounces a raw push-button level, then
// emits one-cycle click / long_press pulses, a debounced level and a
// saturating click counter for the game logic.
// Optional feature macro: CLICK_AUTOREPEAT_EN. When it is defined, a held
// button emits a repeat click every REPEAT_CYCLES cycles after long_press.
module click_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter int unsigned LONG_PRESS_CYCLES = 64,
    parameter int unsigned REPEAT_CYCLES     = 32,
    parameter int unsigned CNT_W             = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       enable,
    input  logic       clear,
    output logic       click,
    output logic       long_press,
    output logic       pressed,
    output logic [4:0] click_count
);

    localparam int unsigned COUNT_W    = 5;
    localparam int unsigned MAX_CYCLES =
        (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES)
            ? ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES)
            : ((LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES);

    localparam logic [CNT_W-1:0]   DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LP_LAST   = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    // Reject parameter sets the counters cannot represent
    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        (64'd1 << CNT_W) < 64'(MAX_CYCLES)) begin : g_param_check
        $error("click_conditioner: invalid cycle parameters for CNT_W");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               s1;
    logic               btn_s;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   hold_next;
    logic               lp_done;
    logic               lp_done_next;
    logic               click_next;
    logic               long_next;
    logic               pressed_next;
    logic [COUNT_W-1:0] count_next;

`ifdef CLICK_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_next;
`endif

    // Two-flop synchronizer for the asynchronous button level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= btn_raw;
            btn_s <= s1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counters and pulse decisions
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        hold_next    = hold_cnt;
        lp_done_next = lp_done;
        pressed_next = pressed;
        click_next   = 1'b0;
        long_next    = 1'b0;
`ifdef CLICK_AUTOREPEAT_EN
        rep_next     = rep_cnt;
`endif
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = PRESS_DB;
                    cnt_next   = '0;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_next   = HELD;
                    pressed_next = 1'b1;
                    cnt_next     = '0;
                    hold_next    = '0;
                    lp_done_next = 1'b0;
                    click_next   = enable;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next = RELEASE_DB;
                    cnt_next   = '0;
                end else if (!lp_done) begin
                    if (hold_cnt == LP_LAST) begin
                        long_next    = enable;
                        lp_done_next = 1'b1;
`ifdef CLICK_AUTOREPEAT_EN
                        rep_next     = '0;
`endif
                    end else begin
                        hold_next = hold_cnt + CNT_ONE;
                    end
                end
`ifdef CLICK_AUTOREPEAT_EN
                else if (rep_cnt == RP_LAST) begin
                    click_next = enable;
                    rep_next   = '0;
                end else begin
                    rep_next = rep_cnt + CNT_ONE;
                end
`endif
            end
            RELEASE_DB: begin
                if (btn_s) begin
                    // Glitch: resume the hold where it left off, no new pulses
                    state_next = HELD;
`ifdef CLICK_AUTOREPEAT_EN
                    rep_next   = '0;
`endif
                end else if (cnt == DB_LAST) begin
                    state_next   = IDLE;
                    pressed_next = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        count_next = click_count;
        if (clear) begin
            count_next = '0;
        end else if (click_next && (click_count != COUNT_MAX)) begin
            count_next = click_count + COUNT_ONE;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            hold_cnt    <= '0;
            lp_done     <= 1'b0;
            pressed     <= 1'b0;
            click       <= 1'b0;
            long_press  <= 1'b0;
            click_count <= '0;
`ifdef CLICK_AUTOREPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            cnt         <= cnt_next;
            hold_cnt    <= hold_next;
            lp_done     <= lp_done_next;
            pressed     <= pressed_next;
            click       <= click_next;
            long_press  <= long_next;
            click_count <= count_next;
`ifdef CLICK_AUTOREPEAT_EN
            rep_cnt     <= rep_next;
`endif
        end
    end

endmodule
